msr_requester: RTL and testbench
================================

# msr_requester

Initiator side of the MSR sample hand-off. It issues a `data_req` pulse to the MSR transfer responder and waits for `data_rdy`. It then captures the 24-bit `msr_data` word and presents it downstream with a one-cycle valid strobe. It supports single-shot and free-running acquisition, with a timeout on both handshake phases and wrap/saturate statistics counters.

## Interface
- `DATA_W`, default 24: width of `msr_data` and `sample_data`.
- `REQ_CYCLES`, default 2: minimum `data_req` high time in clocks; must be ≥1.
- `TIMEOUT`, default 255: maximum clocks spent waiting in WAIT or RELEASE before an error; must be ≥1.
- `PERIOD`, default 1000: clocks between request starts in free-running mode; must be greater than `REQ_CYCLES`.
- `ref_clk` in 1: the block's single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: single-shot request; acted on only in IDLE.
- `auto_en` in 1: free-running mode enable.
- `data_rdy` in 1: responder ready, synchronous to `ref_clk`.
- `msr_data` in `DATA_W`: responder data; valid while `data_rdy` is high.
- `data_req` out 1: request to the responder; registered.
- `sample_data` out `DATA_W`: last captured word; holds until the next capture.
- `sample_valid` out 1: one-cycle strobe marking new `sample_data`.
- `timeout_err` out 1: one-cycle strobe on a handshake timeout.
- `busy` out 1: high in every state except IDLE.
- `sample_count` out 16: number of successful captures; wraps at 0xFFFF→0.
- `err_count` out 8: number of timeouts; saturates at 0xFF.

## Operation
- States: IDLE, REQ, WAIT, RELEASE.
- IDLE:
  - A request triggers when `start` is 1, or when `auto_en` is 1 and the period counter is 0.
  - On a trigger, go to REQ and set `data_req`=1. The timeout counter and request counter clear.
- REQ:
  - `data_req` stays 1 for `REQ_CYCLES` cycles, then the FSM moves to WAIT with `data_req` still 1.
  - If `data_rdy`=1 in any REQ cycle, capture immediately, as described under WAIT.
- WAIT:
  - `data_req` stays 1.
  - If `data_rdy`=1: latch `msr_data` into `sample_data`, pulse `sample_valid` on the next cycle, increment `sample_count`, set `data_req`=0, and go to RELEASE.
  - If the timeout counter reaches `TIMEOUT` first: `data_req`=0, pulse `timeout_err`, increment `err_count` (saturating), and go to IDLE.
- RELEASE:
  - Wait for `data_rdy`=0, then go to IDLE.
  - The timeout counter restarts on entry to RELEASE. Reaching `TIMEOUT` gives the same error action as in WAIT, then IDLE.
- The timeout counter counts cycles spent in REQ+WAIT, and separately cycles spent in RELEASE. It is wide enough for `TIMEOUT` and never wraps.
- Period counter:
  - Loads `PERIOD`-1 on each trigger and decrements to 0 in every state. It holds 0 in IDLE until a trigger.
  - If the period counter is already 0 when the FSM returns to IDLE, the next request issues on the following cycle.
  - With `auto_en`=0 the counter holds at 0.
- `start` or `auto_en` asserted outside IDLE is ignored. There is no queueing.
- `start` and `auto_en` triggering together produce one request.
- Deasserting `auto_en` mid-transaction lets the current transaction complete.
- Captured data passes through without any transformation.

## Timing
- Reset values of all outputs: `data_req`=0, `sample_data`=0, `sample_valid`=0, `timeout_err`=0, `busy`=0, `sample_count`=0, `err_count`=0. State is IDLE.
- Asserting `rst_n` low at any time forces these values asynchronously. This includes mid-transaction, where `data_req` drops immediately.
- Trigger to `data_req`: `start` high at edge k gives `data_req`=1 from after edge k, i.e. one-cycle latency.
- `data_rdy` to capture:
  - `data_rdy` sampled high at edge m latches `sample_data` and drops `data_req` at edge m.
  - `sample_valid`=1 for the cycle after edge m; `sample_data` is already stable in that cycle.
  - `sample_count` updates at edge m.
- Minimum transaction, with `data_rdy` already high and returning low one cycle after the drop of `data_req`: 3 cycles from trigger back to IDLE.
- Timeout latency: `timeout_err` pulses exactly `REQ_CYCLES`+`TIMEOUT` cycles after `data_req` rises, provided `TIMEOUT`≥`REQ_CYCLES`; otherwise the counter spans REQ+WAIT as defined.
- `sample_valid` and `timeout_err` are never high in the same cycle.

## Test plan
- Single shot:
  - Stimulus: `start` pulse; responder raises `data_rdy` 5 cycles after `data_req`, with `msr_data`=0xA5C3F1.
  - Required: `data_req` high for exactly 5 cycles; `sample_data`=0xA5C3F1; one `sample_valid` pulse; `sample_count`=1.
- Timeout:
  - Stimulus: `TIMEOUT`=8, `REQ_CYCLES`=2, `data_rdy` held at 0.
  - Required: `timeout_err` pulse 10 cycles after `data_req` rises; `data_req`=0 afterwards; `err_count`=1; `sample_data` unchanged.
- Free-running:
  - Stimulus: `PERIOD`=20, `auto_en`=1 for 100 cycles; responder answers in 3 cycles.
  - Required: `data_req` rising edges exactly 20 cycles apart; `sample_count`=5.
- Stuck ready:
  - Stimulus: `data_rdy` held high after capture.
  - Required: capture occurs; RELEASE times out; `timeout_err` pulses; `err_count` increments; no second capture.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n` low while `data_req`=1.
  - Required: all outputs return to reset values without waiting for a clock edge.
  - Then: `start` after release of reset gives a normal transaction.
- Counter limits:
  - Stimulus: preload `sample_count` to 0xFFFF and `err_count` to 0xFF by force, then run one capture and one timeout.
  - Required: `sample_count`=0; `err_count`=0xFF.

Source files
------------

// File: rtl/msr_requester.sv
// msr_requester: initiator side of the MSR sample hand-off.
// Issues a data_req pulse, waits for data_rdy, captures msr_data and
// presents it with a one-cycle valid strobe. Supports single-shot and
// free-running acquisition, handshake timeouts and statistics counters.
module msr_requester #(
   parameter int DATA_W     = 24,
   parameter int REQ_CYCLES = 2,
   parameter int TIMEOUT    = 255,
   parameter int PERIOD     = 1000
) (
   input  logic              ref_clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              auto_en,
   input  logic              data_rdy,
   input  logic [DATA_W-1:0] msr_data,
   output logic              data_req,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   output logic              timeout_err,
   output logic              busy,
   output logic [15:0]       sample_count,
   output logic [7:0]        err_count
);

   // Timeout counter spans REQ+WAIT, so it must hold REQ_CYCLES+TIMEOUT.
   localparam int TMO_W = $clog2(REQ_CYCLES + TIMEOUT + 1);
   localparam int RC_W  = $clog2(REQ_CYCLES + 1);
   localparam int PER_W = $clog2(PERIOD + 1);

   localparam logic [TMO_W-1:0] TMO_MAX      = TMO_W'(REQ_CYCLES + TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_WAIT_LIM = TMO_W'(REQ_CYCLES + TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_REL_LIM  = TMO_W'(TIMEOUT - 1);
   localparam logic [RC_W-1:0]  RC_LAST      = RC_W'(REQ_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LOAD     = PER_W'(PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             trigger;
   logic             capture;
   logic             tmo_fire;
   logic [TMO_W-1:0] tmo_cnt;
   logic [RC_W-1:0]  req_cnt;
   logic [PER_W-1:0] per_cnt;

   // Error counter saturates so a long-running fault never reads as "few errors".
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // State register.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and per-cycle handshake events.
   always_comb begin
      state_nxt = state;
      trigger   = 1'b0;
      capture   = 1'b0;
      tmo_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (start || (auto_en && per_cnt == '0)) begin
               trigger   = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            // Early ready is taken without waiting for the minimum request time.
            if (data_rdy) begin
               capture   = 1'b1;
               state_nxt = RELEASE;
            end else if (req_cnt == RC_LAST) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (data_rdy) begin
               capture   = 1'b1;
               state_nxt = RELEASE;
            end else if (tmo_cnt >= TMO_WAIT_LIM) begin
               tmo_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         RELEASE: begin
            if (!data_rdy) begin
               state_nxt = IDLE;
            end else if (tmo_cnt >= TMO_REL_LIM) begin
               tmo_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake timers: request-length, timeout and free-running period.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         req_cnt <= '0;
         per_cnt <= '0;
      end else begin
         // Restarts on trigger and again on entry to RELEASE; never wraps.
         if (trigger || capture)
            tmo_cnt <= '0;
         else if (state != IDLE && tmo_cnt != TMO_MAX)
            tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (trigger)
            req_cnt <= '0;
         else if (state == REQ)
            req_cnt <= req_cnt + RC_W'(1);

         if (!auto_en)
            per_cnt <= '0;
         else if (trigger)
            per_cnt <= PER_LOAD;
         else if (per_cnt != '0)
            per_cnt <= per_cnt - PER_W'(1);
      end
   end

   // Registered outputs: request line, captured word, strobes and statistics.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_req     <= 1'b0;
         sample_data  <= '0;
         sample_valid <= 1'b0;
         timeout_err  <= 1'b0;
         sample_count <= '0;
         err_count    <= '0;
      end else begin
         data_req     <= (state_nxt == REQ) || (state_nxt == WAIT);
         sample_valid <= capture;
         timeout_err  <= tmo_fire;
         if (capture) begin
            sample_data  <= msr_data;
            sample_count <= sample_count + 16'd1;
         end
         if (tmo_fire)
            err_count <= sat_inc8(err_count);
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_msr_requester.sv
// Directed testbench for msr_requester with a behavioural responder.
module tb_msr_requester;

   localparam int DATA_W = 24;

   logic              ref_clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              auto_en;
   logic              data_rdy;
   logic [DATA_W-1:0] msr_data;
   logic              data_req;
   logic [DATA_W-1:0] sample_data;
   logic              sample_valid;
   logic              timeout_err;
   logic              busy;
   logic [15:0]       sample_count;
   logic [7:0]        err_count;

   int n_checks = 0;
   int n_errors = 0;

   // Responder control: 0 = silent, 1 = normal handshake, 2 = ready stuck high
   int                resp_mode = 0;
   int                resp_dly  = 1;
   logic [DATA_W-1:0] resp_word = '0;
   int                rcnt      = 0;

   // Observation statistics
   int   cyc = 0;
   logic prev_req = 1'b0;
   int   req_hi, valid_n, tmo_n, overlap;
   int   last_valid_cyc, last_tmo_cyc;
   int   rise_cyc[$];

   msr_requester #(
      .DATA_W(DATA_W), .REQ_CYCLES(2), .TIMEOUT(8), .PERIOD(20)
   ) dut (
      .ref_clk(ref_clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
      .data_rdy(data_rdy), .msr_data(msr_data), .data_req(data_req),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .timeout_err(timeout_err), .busy(busy), .sample_count(sample_count),
      .err_count(err_count)
   );

   always #5 ref_clk = ~ref_clk;

   // Responder model, acting on falling edges.
   initial begin
      data_rdy = 1'b0;
      msr_data = '0;
      forever begin
         @(negedge ref_clk);
         if (!rst_n || resp_mode == 0) begin
            data_rdy = 1'b0;
            rcnt     = 0;
         end else if (data_req && !data_rdy) begin
            rcnt++;
            if (rcnt == resp_dly) begin
               data_rdy = 1'b1;
               msr_data = resp_word;
            end
         end else if (!data_req && data_rdy && resp_mode == 1) begin
            data_rdy = 1'b0;
            rcnt     = 0;
         end else if (!data_req) begin
            rcnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      req_hi  = 0;
      valid_n = 0;
      tmo_n   = 0;
      rise_cyc.delete();
   endtask

   task automatic sample_now();
      cyc++;
      if (data_req) req_hi++;
      if (data_req && !prev_req) rise_cyc.push_back(cyc);
      prev_req = data_req;
      if (sample_valid) begin valid_n++; last_valid_cyc = cyc; end
      if (timeout_err)  begin tmo_n++;   last_tmo_cyc   = cyc; end
      if (sample_valid && timeout_err) overlap++;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge ref_clk);
         sample_now();
      end
   endtask

   task automatic pulse_start();
      @(negedge ref_clk);
      sample_now();
      start = 1'b1;
      @(negedge ref_clk);
      start = 1'b0;
      sample_now();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"},   {31'd0, data_req},     32'd0);
      check({tag, "_data"},  {8'd0, sample_data},   32'd0);
      check({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
      check({tag, "_tmo"},   {31'd0, timeout_err},  32'd0);
      check({tag, "_busy"},  {31'd0, busy},         32'd0);
      check({tag, "_scnt"},  {16'd0, sample_count}, 32'd0);
      check({tag, "_ecnt"},  {24'd0, err_count},    32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      auto_en = 1'b0;
      overlap = 0;
      clear_stats();
      repeat (3) @(negedge ref_clk);
      check_reset_values("rst");
      rst_n = 1'b1;

      // Single shot: ready 5 cycles after request
      resp_mode = 1; resp_dly = 5; resp_word = 24'hA5C3F1;
      clear_stats();
      pulse_start();
      check("ss_req_latency", {31'd0, data_req}, 32'd1);
      check("ss_busy",        {31'd0, busy},     32'd1);
      run_cycles(20);
      check("ss_req_hi",  req_hi,                32'd5);
      check("ss_valid_n", valid_n,               32'd1);
      check("ss_data",    {8'd0, sample_data},   32'hA5C3F1);
      check("ss_scnt",    {16'd0, sample_count}, 32'd1);
      check("ss_busy_end", {31'd0, busy},        32'd0);

      // Timeout in WAIT: no ready at all
      resp_mode = 0;
      clear_stats();
      pulse_start();
      run_cycles(9);
      check("to_early", tmo_n, 32'd0);
      check("to_req_held", {31'd0, data_req}, 32'd1);
      run_cycles(1);
      check("to_pulse",   {31'd0, timeout_err}, 32'd1);
      check("to_req_low", {31'd0, data_req},    32'd0);
      check("to_ecnt",    {24'd0, err_count},   32'd1);
      check("to_data",    {8'd0, sample_data},  32'hA5C3F1);
      run_cycles(1);
      check("to_one_cycle", {31'd0, timeout_err}, 32'd0);
      check("to_busy", {31'd0, busy}, 32'd0);

      // Stuck ready: capture, then RELEASE timeout, no second capture
      resp_mode = 2; resp_dly = 2; resp_word = 24'h123456;
      clear_stats();
      pulse_start();
      run_cycles(30);
      check("st_valid_n", valid_n,               32'd1);
      check("st_tmo_n",   tmo_n,                 32'd1);
      check("st_gap",     last_tmo_cyc - last_valid_cyc, 32'd8);
      check("st_data",    {8'd0, sample_data},   32'h123456);
      check("st_scnt",    {16'd0, sample_count}, 32'd2);
      check("st_ecnt",    {24'd0, err_count},    32'd2);
      resp_mode = 0;
      run_cycles(2);

      // Asynchronous reset while waiting for ready
      clear_stats();
      pulse_start();
      run_cycles(3);
      check("rw_req_before", {31'd0, data_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_values("rw");
      @(negedge ref_clk);
      rst_n = 1'b1;

      // Minimum transaction after reset
      resp_mode = 1; resp_dly = 1; resp_word = 24'h0F0F0F;
      clear_stats();
      pulse_start();
      run_cycles(1);
      check("mt_valid", {31'd0, sample_valid}, 32'd1);
      check("mt_data",  {8'd0, sample_data},   32'h0F0F0F);
      check("mt_req",   {31'd0, data_req},     32'd0);
      check("mt_busy",  {31'd0, busy},         32'd1);
      run_cycles(1);
      check("mt_idle",  {31'd0, busy},         32'd0);
      check("mt_valid_off", {31'd0, sample_valid}, 32'd0);
      check("mt_scnt",  {16'd0, sample_count}, 32'd1);

      // Free-running with PERIOD=20
      @(negedge ref_clk); rst_n = 1'b0;
      @(negedge ref_clk); rst_n = 1'b1;
      prev_req = 1'b0;
      resp_mode = 1; resp_dly = 3; resp_word = 24'h3C3C3C;
      clear_stats();
      @(negedge ref_clk);
      auto_en = 1'b1;
      sample_now();
      run_cycles(100);
      auto_en = 1'b0;
      run_cycles(20);
      check("fr_rises", rise_cyc.size(), 32'd5);
      for (int i = 1; i < rise_cyc.size(); i++)
         check("fr_spacing", rise_cyc[i] - rise_cyc[i-1], 32'd20);
      check("fr_scnt", {16'd0, sample_count}, 32'd5);
      check("fr_ecnt", {24'd0, err_count},    32'd0);

      // Counter limits: wrap and saturate
      @(negedge ref_clk);
      force dut.sample_count = 16'hFFFF;
      force dut.err_count    = 8'hFF;
      #1;
      release dut.sample_count;
      release dut.err_count;
      resp_mode = 1; resp_dly = 2; resp_word = 24'h000001;
      clear_stats();
      pulse_start();
      run_cycles(10);
      check("lim_scnt_wrap", {16'd0, sample_count}, 32'd0);
      check("lim_data",      {8'd0, sample_data},   32'h000001);
      resp_mode = 0;
      clear_stats();
      pulse_start();
      run_cycles(20);
      check("lim_tmo_n",    tmo_n,               32'd1);
      check("lim_ecnt_sat", {24'd0, err_count},  32'hFF);

      check("no_overlap", overlap, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
